// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic-array operand feeder.
package sa_pkg;

  localparam int SA_N         = 4;
  localparam int SA_DIN_WIDTH = 8;

  typedef logic [SA_DIN_WIDTH-1:0]   sa_elem_t;
  typedef logic [2*SA_DIN_WIDTH-1:0] sa_acc_t;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } sa_feed_state_e;

  // Stream counter covers beats 0..2N-2.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n - 1);
  endfunction

  localparam int CNT_W = cnt_w(SA_N);

endpackage

// File: rtl/sa_feeder_if.sv
// Operand load port plus array-side input bus of the feeder.
interface sa_feeder_if #(
  parameter int N         = 4,
  parameter int DIN_WIDTH = 8
);
  logic                       ld_valid;
  logic                       ld_ready;
  logic [N*DIN_WIDTH-1:0]     ld_a;
  logic [N*DIN_WIDTH-1:0]     ld_b;
  logic [N*2*DIN_WIDTH-1:0]   ld_c;
  logic                       sa_out_valid;
  logic [N*DIN_WIDTH-1:0]     a_din;
  logic [N*DIN_WIDTH-1:0]     b_din;
  logic [N*2*DIN_WIDTH-1:0]   c_din;
  logic                       in_valid;

  // Environment side: operand source and systolic array.
  modport master (
    output ld_valid, ld_a, ld_b, ld_c, sa_out_valid,
    input  ld_ready, a_din, b_din, c_din, in_valid
  );

  // Feeder side.
  modport slave (
    input  ld_valid, ld_a, ld_b, ld_c, sa_out_valid,
    output ld_ready, a_din, b_din, c_din, in_valid
  );
endinterface

// File: rtl/sa_skew_mux.sv
// Diagonal skew select: lane l at stream count t shows mem[t-l][l], or zero outside the diamond.
module sa_skew_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic [N-1:0][N-1:0][W-1:0] mem,   // [beat][lane]
  input  logic [CNT_W-1:0]           t,
  output logic [N-1:0][W-1:0]        lanes
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    int d;
    // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
    d     = 0;
    lanes = '0;
    for (int l = 0; l < N; l++) begin
      d = int'(t) - l;
      if (d >= 0 && d < N) lanes[l] = mem[d[IDX_W-1:0]][l];
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// Loads one NxN A/B operand pair plus a bias row, streams them diagonally skewed into the
// systolic array, then waits for the array's result before accepting the next load.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4
) (
  input  logic           clk,
  input  logic           rst,
  sa_feeder_if.slave     bus,
  output logic           busy,
  output logic           err_stray
);

  localparam int W      = DIN_WIDTH;
  localparam int CW     = 2 * DIN_WIDTH;
  localparam int CNT_W  = cnt_w(N);
  localparam int K_W    = $clog2(N);
  localparam int LAST_T = 2 * N - 2;

  typedef logic [N-1:0][W-1:0]  lanes_t;
  typedef logic [N-1:0][CW-1:0] acc_lanes_t;

  sa_feed_state_e     state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic               primed_q, primed_d;
  lanes_t [N-1:0]     a_buf_q, a_buf_d;    // [beat k] = A column k
  lanes_t [N-1:0]     b_buf_q, b_buf_d;    // [beat k] = B row k
  acc_lanes_t         c_buf_q, c_buf_d;
  lanes_t             a_din_q, a_din_d, b_din_q, b_din_d;
  acc_lanes_t         c_din_q, c_din_d;
  logic               in_valid_q, in_valid_d;
  logic               err_q, err_d;

  logic               ld_fire, last_beat, last_t, stream_beat;
  lanes_t             a_sel, b_sel;

  assign bus.ld_ready = (state_q == S_LOAD) && !rst;
  assign ld_fire      = bus.ld_valid && bus.ld_ready;
  assign last_beat    = (k_q == K_W'(N - 1));
  assign last_t       = (t_q == CNT_W'(LAST_T));
  // The first STREAM cycle only primes the count, giving the two-cycle load-to-beat latency.
  assign stream_beat  = (state_q == S_STREAM) && primed_q;

  // Both buffers are stored beat-major (A as its transpose), so one select serves both.
  sa_skew_mux #(.N(N), .W(W), .CNT_W(CNT_W)) u_mux_a (
    .mem   (a_buf_q),
    .t     (t_q),
    .lanes (a_sel)
  );

  sa_skew_mux #(.N(N), .W(W), .CNT_W(CNT_W)) u_mux_b (
    .mem   (b_buf_q),
    .t     (t_q),
    .lanes (b_sel)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (ld_fire && last_beat)     state_d = S_STREAM;
      S_STREAM: if (stream_beat && last_t)    state_d = S_WAIT;
      S_WAIT:   if (bus.sa_out_valid)         state_d = S_LOAD;
      default:                                state_d = S_LOAD;
    endcase
  end

  always_comb begin
    k_d      = k_q;
    t_d      = t_q;
    primed_d = primed_q;
    a_buf_d  = a_buf_q;
    b_buf_d  = b_buf_q;
    c_buf_d  = c_buf_q;
    if (ld_fire) begin
      a_buf_d[k_q] = bus.ld_a;
      b_buf_d[k_q] = bus.ld_b;
      if (k_q == '0) c_buf_d = bus.ld_c;
      k_d = last_beat ? '0 : k_q + 1'b1;
    end
    if (state_q == S_STREAM) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (last_t) begin
        primed_d = 1'b0;
        t_d      = '0;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_comb begin
    a_din_d    = '0;
    b_din_d    = '0;
    in_valid_d = 1'b0;
    c_din_d    = c_din_q;
    err_d      = err_q || (bus.sa_out_valid && state_q != S_WAIT);
    if (stream_beat) begin
      a_din_d    = a_sel;
      b_din_d    = b_sel;
      c_din_d    = c_buf_q;
      in_valid_d = last_t;
    end
    // Bias output is released when the next operand set starts loading.
    if (ld_fire && k_q == '0) c_din_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      t_q        <= '0;
      primed_q   <= 1'b0;
      // NOTE: operand buffers are plain flops and are cleared on reset like any other state.
      a_buf_q    <= '0;
      b_buf_q    <= '0;
      c_buf_q    <= '0;
      a_din_q    <= '0;
      b_din_q    <= '0;
      c_din_q    <= '0;
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      k_q        <= k_d;
      t_q        <= t_d;
      primed_q   <= primed_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
      c_buf_q    <= c_buf_d;
      a_din_q    <= a_din_d;
      b_din_q    <= b_din_d;
      c_din_q    <= c_din_d;
      in_valid_q <= in_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.a_din    = a_din_q;
  assign bus.b_din    = b_din_q;
  assign bus.c_din    = c_din_q;
  assign bus.in_valid = in_valid_q;
  assign busy         = (state_q != S_LOAD);
  assign err_stray    = err_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: timeline reference model checked every cycle plus pinned literals.
module tb_sa_feeder;
  import sa_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2 * W;

  logic clk = 1'b0;
  logic rst;
  logic busy, err_stray;

  always #5 clk = ~clk;

  sa_feeder_if #(.N(N), .DIN_WIDTH(W)) bus ();

  sa_feeder #(.DIN_WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_stray (err_stray)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: timeline relative to the last load completion ----------------
  int              m_cyc     = 0;
  bit              m_loading = 1'b1;
  int              m_beats   = 0;
  int              m_done    = -1000;
  bit              m_err     = 1'b0;
  sa_elem_t        m_a [N][N];
  sa_elem_t        m_b [N][N];
  logic [N*CW-1:0] m_bias    = '0;
  logic [N*CW-1:0] m_c       = '0;

  always @(posedge clk) begin
    bit release_now;
    release_now = 1'b0;
    m_cyc++;
    if (rst) begin
      m_loading = 1'b1;
      m_beats   = 0;
      m_done    = -1000;
      m_err     = 1'b0;
      m_c       = '0;
    end else begin
      if (bus.sa_out_valid) begin
        if (!m_loading && (m_cyc - 1) >= m_done + 2 * N) release_now = 1'b1;
        else m_err = 1'b1;
      end
      if (m_loading && bus.ld_valid) begin
        for (int i = 0; i < N; i++) begin
          m_a[i][m_beats] = bus.ld_a[i*W +: W];
          m_b[m_beats][i] = bus.ld_b[i*W +: W];
        end
        if (m_beats == 0) begin
          m_bias = bus.ld_c;
          m_c    = '0;
        end
        m_beats++;
        if (m_beats == N) begin
          m_loading = 1'b0;
          m_done    = m_cyc;
        end
      end
      if (!m_loading && m_cyc == m_done + 2) m_c = m_bias;
      if (release_now) begin
        m_loading = 1'b1;
        m_beats   = 0;
      end
    end
  end

  function automatic logic [N*W-1:0] exp_lanes(input bit is_b);
    logic [N*W-1:0] r;
    int rel, t;
    r   = '0;
    rel = m_cyc - m_done;
    if (!m_loading && rel >= 2 && rel <= 2 * N) begin
      t = rel - 2;
      for (int l = 0; l < N; l++)
        if (t >= l && t - l < N) r[l*W +: W] = is_b ? m_b[t-l][l] : m_a[l][t-l];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_cyc > 0) begin
      check("a_din",     64'(bus.a_din),    64'(exp_lanes(1'b0)));
      check("b_din",     64'(bus.b_din),    64'(exp_lanes(1'b1)));
      check("c_din",     64'(bus.c_din),    64'(m_c));
      check("in_valid",  64'(bus.in_valid), 64'(!m_loading && (m_cyc - m_done == 2 * N)));
      check("busy",      64'(busy),         64'(!m_loading));
      check("ld_ready",  64'(bus.ld_ready), 64'(m_loading && !rst));
      check("err_stray", 64'(err_stray),    64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  sa_elem_t        s_a [N][N];
  sa_elem_t        s_b [N][N];
  logic [N*CW-1:0] s_c;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        s_a[i][k] = sa_elem_t'(16 * i + k);
        s_b[i][k] = sa_elem_t'(16 * i + k + 8'h80);
      end
    s_c = {$urandom, $urandom};
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        s_a[i][k] = sa_elem_t'($urandom);
        s_b[i][k] = sa_elem_t'($urandom);
      end
    s_c = {$urandom, $urandom};
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps with random stray out_valid.
  task automatic do_load(input int mode, output int used);
    int   budget;
    logic v;
    budget = 100;
    used   = 0;
    while (m_loading && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (used % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.ld_valid     = v;
      bus.sa_out_valid = (mode == 2) && ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        bus.ld_a[i*W +: W] = v ? s_a[i][m_beats] : sa_elem_t'($urandom);
        bus.ld_b[i*W +: W] = v ? s_b[m_beats][i] : sa_elem_t'($urandom);
      end
      bus.ld_c = (m_beats == 0) ? s_c : {$urandom, $urandom};
      used++;
      budget--;
      step();
    end
    bus.ld_valid     = 1'b0;
    bus.sa_out_valid = 1'b0;
    if (budget == 0) check("load_budget", 64'(m_loading), 64'(0));
  endtask

  task automatic release_wait(input int hold, input int stray_at);
    for (int c = 0; c < hold; c++) begin
      bus.sa_out_valid = (c == stray_at);
      step();
    end
    bus.sa_out_valid = 1'b1;
    step();
    bus.sa_out_valid = 1'b0;
    check("release_ready", 64'(bus.ld_ready), 64'(1));
  endtask

  initial begin
    int used;
    rst              = 1'b1;
    bus.ld_valid     = 1'b0;
    bus.ld_a         = '0;
    bus.ld_b         = '0;
    bus.ld_c         = '0;
    bus.sa_out_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_ready",    64'(bus.ld_ready), 64'(1));
    check("rst_busy",     64'(busy),         64'(0));
    check("rst_a_din",    64'(bus.a_din),    64'(0));
    check("rst_c_din",    64'(bus.c_din),    64'(0));
    check("rst_err",      64'(err_stray),    64'(0));

    // Basic skew with hand-computed beats.
    set_basic();
    do_load(0, used);
    check("basic_cycles", 64'(used), 64'(4));
    check("basic_ready",  64'(bus.ld_ready), 64'(0));
    repeat (5) step();
    check("basic_t3_a",   64'(bus.a_din),    64'(32'h30211203));
    check("basic_t3_b",   64'(bus.b_din),    64'(32'h8392A1B0));
    check("basic_t3_iv",  64'(bus.in_valid), 64'(0));
    repeat (3) step();
    check("basic_t6_a3",  64'(bus.a_din[31:24]), 64'(8'h33));
    check("basic_t6_b3",  64'(bus.b_din[31:24]), 64'(8'hB3));
    check("basic_t6_iv",  64'(bus.in_valid),     64'(1));
    step();
    check("basic_after_iv", 64'(bus.in_valid), 64'(0));
    check("basic_after_a",  64'(bus.a_din),    64'(0));
    release_wait(1, -1);

    // Load stall: 4 beats over 7 cycles, same stream.
    set_basic();
    do_load(1, used);
    check("stall_cycles", 64'(used), 64'(7));
    repeat (5) step();
    check("stall_t3_a",   64'(bus.a_din), 64'(32'h30211203));
    release_wait(2 * N, -1);

    // Bias capture and long handshake hold.
    set_random();
    s_c = 64'hDEF0_9ABC_5678_1234;
    do_load(0, used);
    repeat (4) step();
    check("bias_mid",     64'(bus.c_din), 64'hDEF0_9ABC_5678_1234);
    repeat (2 * N - 4) step();
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_busy",  64'(busy),         64'(1));
      check("hold_ready", 64'(bus.ld_ready), 64'(0));
    end
    check("bias_hold",    64'(bus.c_din), 64'hDEF0_9ABC_5678_1234);
    bus.sa_out_valid = 1'b1;
    step();
    bus.sa_out_valid = 1'b0;
    check("hs_ready",     64'(bus.ld_ready), 64'(1));

    // Randomized transactions, including stray out_valid during load and stream.
    repeat (12) begin
      set_random();
      do_load($urandom_range(0, 2), used);
      release_wait(2 * N + $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? 3 : -1);
    end

    // Reset held 3 cycles mid-stream.
    set_basic();
    do_load(0, used);
    repeat (4) step();
    rst = 1'b1;
    step();
    check("midrst_a",     64'(bus.a_din),    64'(0));
    check("midrst_busy",  64'(busy),         64'(0));
    check("midrst_ready", 64'(bus.ld_ready), 64'(0));
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("midrst_ready_after", 64'(bus.ld_ready), 64'(1));
    check("midrst_err",         64'(err_stray),    64'(0));
    check("midrst_c",           64'(bus.c_din),    64'(0));
    set_basic();
    do_load(0, used);
    repeat (5) step();
    check("midrst_t3_a", 64'(bus.a_din), 64'(32'h30211203));
    release_wait(2 * N, -1);

    // Stray out_valid during load: sticky flag, FSM unaffected.
    bus.sa_out_valid = 1'b1;
    step();
    bus.sa_out_valid = 1'b0;
    check("stray_err",   64'(err_stray),    64'(1));
    check("stray_busy",  64'(busy),         64'(0));
    check("stray_ready", 64'(bus.ld_ready), 64'(1));
    set_random();
    do_load(0, used);
    release_wait(2 * N, -1);
    check("stray_sticky", 64'(err_stray), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("stray_cleared", 64'(err_stray), 64'(0));

    // out_valid on the last-beat edge is stray; block still enters WAIT.
    set_random();
    do_load(0, used);
    repeat (2 * N - 1) step();
    bus.sa_out_valid = 1'b1;
    step();
    bus.sa_out_valid = 1'b0;
    check("bound_err",   64'(err_stray),    64'(1));
    check("bound_iv",    64'(bus.in_valid), 64'(1));
    step();
    check("bound_busy",  64'(busy),         64'(1));
    check("bound_ready", 64'(bus.ld_ready), 64'(0));
    bus.sa_out_valid = 1'b1;
    step();
    bus.sa_out_valid = 1'b0;
    check("bound_release", 64'(bus.ld_ready), 64'(1));
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
